// File: rtl/dco_ctrl_pkg.sv
// dco_ctrl_pkg
// Shared types and constants for the DCO tuning controller: calibration
// state encoding, reset/mid codes and default bus widths.
package dco_ctrl_pkg;

  localparam int DCTRL_W_DEF    = 9;
  localparam int TC_W_DEF       = 4;
  localparam int FRAC_W_DEF     = 8;
  localparam int SETTLE_CYC_DEF = 16;

  // Mid-scale starting points: the coarse SAR trial begins with only the
  // MSB set, the tracking bank sits at half range until the loop takes over.
  localparam int DCTRL_MID = 256;
  localparam int TC_MID    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_CMP = 2'd2,
    TRACK    = 2'd3
  } dco_cal_state_t;

endpackage

// File: rtl/dco_tc_dsm.sv
// dco_tc_dsm
// First-order delta-sigma modulator for the fractional part of the tracking
// word. Each enabled cycle the fraction is added to an accumulator; the carry
// out becomes the registered dither bit, so the mean of the bit equals
// frac / 2^FRAC_W.
// Ports:
//   CLK, NRST : clock, async active-low reset
//   en        : accumulate this cycle (hold otherwise)
//   clr       : synchronous clear of accumulator and output (wins over en)
//   frac      : FRAC_W-bit fraction
//   carry     : registered dither bit
module dco_tc_dsm
  import dco_ctrl_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              en,
  input  logic              clr,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (en) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;

endmodule

// File: rtl/dco_tune_ctrl.sv
// dco_tune_ctrl
// DCO digital tuning controller. A calibration request runs a binary
// (successive-approximation) search of the coarse bank driven by a
// frequency-comparator sign, then the block enters tracking where the
// loop-filter word is split into an integer tracking code and a first-order
// delta-sigma dither bit.
// Ports:
//   CLK, NRST            : reference clock, async active-low reset
//   CAL_START            : one-cycle pulse, (re)starts calibration from any state
//   FERR_VALID/FERR_FAST : comparator strobe and sign (1 = DCO too fast)
//   LF_VALID/LF_WORD     : loop-filter strobe and unsigned Q(TC_W).(FRAC_W) word
//   DCTRL                : coarse bank code
//   DCTRLTC              : tracking bank integer code
//   DCTRLTCDSM           : dither unit, same weight as one DCTRLTC LSB
//   CAL_DONE             : high in TRACK
//   BUSY                 : high while searching (SETTLE / WAIT_CMP)
module dco_tune_ctrl
  import dco_ctrl_pkg::*;
#(
  parameter int DCTRL_W    = DCTRL_W_DEF,
  parameter int TC_W       = TC_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   CAL_START,
  input  logic                   FERR_VALID,
  input  logic                   FERR_FAST,
  input  logic                   LF_VALID,
  input  logic [TC_W+FRAC_W-1:0] LF_WORD,
  output logic [DCTRL_W-1:0]     DCTRL,
  output logic [TC_W-1:0]        DCTRLTC,
  output logic                   DCTRLTCDSM,
  output logic                   CAL_DONE,
  output logic                   BUSY
);

  localparam int PTR_W = (DCTRL_W > 1) ? $clog2(DCTRL_W) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  localparam logic [DCTRL_W-1:0] DCTRL_RST  = DCTRL_W'(DCTRL_MID);
  localparam logic [TC_W-1:0]    TC_RST     = TC_W'(TC_MID);
  localparam logic [PTR_W-1:0]   PTR_MSB    = PTR_W'(DCTRL_W - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SETTLE_CYC - 1);

  dco_cal_state_t      state_q, state_d;
  logic [DCTRL_W-1:0]  dctrl_q, dctrl_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TC_W-1:0]     tc_q, tc_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                cal_done_q, cal_done_d;
  logic                busy_q, busy_d;
  logic                dsm_en, dsm_clr;

  always_comb begin
    state_d = state_q;
    dctrl_d = dctrl_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    frac_d  = frac_q;
    dsm_clr = 1'b0;

    // A calibration request overrides whatever strobe arrives with it.
    if (CAL_START) begin
      state_d = SETTLE;
      dctrl_d = DCTRL_RST;
      ptr_d   = PTR_MSB;
      cnt_d   = '0;
      tc_d    = TC_RST;
      frac_d  = '0;
      dsm_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = WAIT_CMP;
        end
        WAIT_CMP: begin
          if (FERR_VALID) begin
            // Too fast: the trial bit overshoots, drop it.
            if (FERR_FAST) dctrl_d[ptr_q] = 1'b0;
            if (ptr_q != '0) begin
              dctrl_d[ptr_q - PTR_W'(1)] = 1'b1;
              ptr_d   = ptr_q - PTR_W'(1);
              cnt_d   = '0;
              state_d = SETTLE;
            end else begin
              state_d = TRACK;
            end
          end
        end
        TRACK: begin
          if (LF_VALID) begin
            tc_d   = LF_WORD[TC_W+FRAC_W-1:FRAC_W];
            frac_d = LF_WORD[FRAC_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status flags follow the next state so they switch on the same edge
    // as the state itself while still coming straight from flops.
    cal_done_d = (state_d == TRACK);
    busy_d     = (state_d == SETTLE) || (state_d == WAIT_CMP);
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= IDLE;
      dctrl_q    <= DCTRL_RST;
      ptr_q      <= PTR_MSB;
      cnt_q      <= '0;
      tc_q       <= TC_RST;
      frac_q     <= '0;
      cal_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dctrl_q    <= dctrl_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tc_q       <= tc_d;
      frac_q     <= frac_d;
      cal_done_q <= cal_done_d;
      busy_q     <= busy_d;
    end
  end

  // The modulator sees the registered fraction, so a new LF word shows up
  // on the dither bit one edge after it lands in DCTRLTC.
  assign dsm_en = (state_q == TRACK) && !CAL_START;

  dco_tc_dsm #(.FRAC_W(FRAC_W)) u_dsm (
    .CLK   (CLK),
    .NRST  (NRST),
    .en    (dsm_en),
    .clr   (dsm_clr),
    .frac  (frac_q),
    .carry (DCTRLTCDSM)
  );

  assign DCTRL    = dctrl_q;
  assign DCTRLTC  = tc_q;
  assign CAL_DONE = cal_done_q;
  assign BUSY     = busy_q;

endmodule
